// File: rtl/cic_sched_pkg.sv
// Shared types and helpers for the CIC array scheduler: capture FSM states,
// minimum decimation ratio and the packed-channel slice offset.
package cic_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } sched_state_t;

   localparam int unsigned MIN_RATIO = 2;

   function automatic int unsigned chan_lsb(input int unsigned chan, input int unsigned w);
      return chan * w;
   endfunction

endpackage

// File: rtl/cic_strobe_gen.sv
// PDM clock, integrator enable and comb enable generation for the CIC bank.
// Everything runs on clk; the decimation ratio is latched only on frame boundaries.
module cic_strobe_gen
   import cic_sched_pkg::*;
#(
   parameter int unsigned DIV_W    = 8,
   parameter int unsigned PDM_HALF = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [DIV_W-1:0] decim_ratio,
   output logic             pdm_clk,
   output logic             pdm_sample_en,
   output logic             decim_en
);

   localparam int unsigned      PW       = (PDM_HALF > 1) ? $clog2(PDM_HALF) : 1;
   localparam logic [PW-1:0]    PDM_LAST = PW'(PDM_HALF - 1);
   localparam logic [DIV_W-1:0] RMIN     = DIV_W'(MIN_RATIO);

   logic             en_q;
   logic [PW-1:0]    pdm_cnt;
   logic [DIV_W-1:0] decim_cnt;
   logic [DIV_W-1:0] r_lat;
   logic [DIV_W-1:0] r_eff;

   assign r_eff = (decim_ratio < RMIN) ? RMIN : decim_ratio;

   // The cycle enable is first seen only latches the ratio, so the first
   // pdm_clk rise lands PDM_HALF cycles after that sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q          <= 1'b0;
         pdm_cnt       <= '0;
         decim_cnt     <= '0;
         r_lat         <= '0;
         pdm_clk       <= 1'b0;
         pdm_sample_en <= 1'b0;
         decim_en      <= 1'b0;
      end else begin
         en_q          <= enable;
         pdm_sample_en <= 1'b0;
         decim_en      <= 1'b0;
         if (!enable) begin
            pdm_cnt   <= '0;
            decim_cnt <= '0;
            pdm_clk   <= 1'b0;
         end else if (!en_q) begin
            r_lat <= r_eff;
         end else begin
            if (pdm_cnt == PDM_LAST) begin
               pdm_cnt       <= '0;
               pdm_clk       <= ~pdm_clk;
               pdm_sample_en <= ~pdm_clk;
            end else begin
               pdm_cnt <= pdm_cnt + 1'b1;
            end
            if (pdm_sample_en) begin
               if (decim_cnt == r_lat - 1'b1) begin
                  decim_cnt <= '0;
                  decim_en  <= 1'b1;
                  r_lat     <= r_eff;
               end else begin
                  decim_cnt <= decim_cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/cic_array_scheduler.sv
// Sequences a bank of NCH PDM CIC decimators on clk and serialises each
// decimated frame to the beamformer as a valid/ready stream, one word per channel.
module cic_array_scheduler
   import cic_sched_pkg::*;
#(
   parameter int unsigned NCH      = 8,
   parameter int unsigned W        = 16,
   parameter int unsigned DIV_W    = 8,
   parameter int unsigned PDM_HALF = 25,
   parameter int unsigned COMB_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [DIV_W-1:0]        decim_ratio,
   output logic                    pdm_clk,
   output logic                    pdm_sample_en,
   output logic                    decim_en,
   input  logic [NCH*W-1:0]        cic_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [W-1:0]            m_data,
   output logic [$clog2(NCH)-1:0]  m_chan,
   output logic                    m_first,
   output logic                    m_last,
   output logic                    overrun,
   input  logic                    clear_overrun,
   output logic                    busy
);

   localparam int unsigned   CW      = $clog2(NCH);
   localparam int unsigned   LW      = (COMB_LAT > 1) ? $clog2(COMB_LAT + 1) : 1;
   localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

   sched_state_t          state;
   logic                  pend;
   logic [LW-1:0]         dly;
   logic [NCH-1:0][W-1:0] frame;
   logic [CW-1:0]         chan_nxt;
   logic                  xfer;
   logic                  capture_pt;
   logic                  do_load;
   logic                  do_adv;
   logic                  do_end;
   logic                  drop;

   cic_strobe_gen #(
      .DIV_W    (DIV_W),
      .PDM_HALF (PDM_HALF)
   ) u_strobe (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .decim_ratio   (decim_ratio),
      .pdm_clk       (pdm_clk),
      .pdm_sample_en (pdm_sample_en),
      .decim_en      (decim_en)
   );

   assign chan_nxt = m_chan + 1'b1;

   // The comb-latency delay runs independently of the FSM state so that a
   // capture point falling inside DRAIN can be recognised and dropped.
   always_comb begin
      xfer       = m_valid && m_ready;
      capture_pt = pend && (dly <= LW'(1));
      do_adv     = (state == DRAIN) && xfer && !m_last;
      do_load    = capture_pt && ((state == WAIT) || ((state == DRAIN) && xfer && m_last));
      do_end     = (state == DRAIN) && xfer && m_last && !capture_pt;
      drop       = capture_pt && (state == DRAIN) && !(xfer && m_last);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pend    <= 1'b0;
         dly     <= '0;
         frame   <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_chan  <= '0;
         m_first <= 1'b0;
         m_last  <= 1'b0;
         overrun <= 1'b0;
         busy    <= 1'b0;
      end else begin
         if (decim_en) begin
            pend <= 1'b1;
            dly  <= LW'(COMB_LAT);
         end else if (capture_pt) begin
            pend <= 1'b0;
         end else if (pend) begin
            dly <= dly - 1'b1;
         end

         if (do_load) begin
            for (int unsigned k = 0; k < NCH; k++) begin
               frame[k] <= cic_data[chan_lsb(k, W) +: W];
            end
            m_valid <= 1'b1;
            m_data  <= cic_data[chan_lsb(0, W) +: W];
            m_chan  <= '0;
            m_first <= 1'b1;
            m_last  <= (NCH == 1);
            state   <= DRAIN;
            busy    <= 1'b1;
         end else if (do_adv) begin
            m_data  <= frame[chan_nxt];
            m_chan  <= chan_nxt;
            m_first <= 1'b0;
            m_last  <= (chan_nxt == LAST_CH);
         end else if (do_end) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= '0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
            if (decim_en || pend) begin
               state <= WAIT;
            end else begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         end else if ((state == IDLE) && decim_en) begin
            state <= WAIT;
            busy  <= 1'b1;
         end

         if (drop) begin
            overrun <= 1'b1;
         end else if (clear_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cic_array_scheduler.sv
// Directed-plus-random bench for cic_array_scheduler against a timeline/queue reference model.
module tb_cic_array_scheduler;

   localparam int unsigned NCH = 4;
   localparam int unsigned W   = 16;
   localparam int unsigned DW  = 8;
   localparam int          PH  = 2;
   localparam int          CL  = 1;

   typedef struct packed {
      logic [W-1:0] d;
      logic [1:0]   ch;
   } word_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, enable, m_ready, clear_overrun;
   logic [DW-1:0]    decim_ratio;
   logic [NCH*W-1:0] cic_data;
   logic             pdm_clk, pdm_sample_en, decim_en, m_valid, m_first, m_last, overrun, busy;
   logic [W-1:0]     m_data;
   logic [1:0]       m_chan;

   cic_array_scheduler #(
      .NCH      (NCH),
      .W        (W),
      .DIV_W    (DW),
      .PDM_HALF (PH),
      .COMB_LAT (CL)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .decim_ratio   (decim_ratio),
      .pdm_clk       (pdm_clk),
      .pdm_sample_en (pdm_sample_en),
      .decim_en      (decim_en),
      .cic_data      (cic_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .m_chan        (m_chan),
      .m_first       (m_first),
      .m_last        (m_last),
      .overrun       (overrun),
      .clear_overrun (clear_overrun),
      .busy          (busy)
   );

   int    tests = 0;
   int    fails = 0;
   int    ec = 0;
   bit    run = 0;
   int    e0 = 0;
   int    next_decim = 0;
   int    pend_d[$];
   word_t q[$];
   bit    ovr = 0, ex_pdm = 0, ex_se = 0, ex_de = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int clampr(input int r);
      return (r < 2) ? 2 : r;
   endfunction

   // Reference: strobes from absolute edge positions, stream as a word queue.
   task automatic model_edge();
      int  k;
      bit  ovr_set;
      ec++;
      if (rst) begin
         run = 0; q.delete(); pend_d.delete();
         ovr = 0; ex_pdm = 0; ex_se = 0; ex_de = 0;
      end else begin
         if (q.size() != 0 && m_ready) void'(q.pop_front());
         ex_se = 0; ex_de = 0; ovr_set = 0;
         if (!enable) begin
            run = 0; ex_pdm = 0;
         end else if (!run) begin
            run = 1; e0 = ec; ex_pdm = 0;
            next_decim = ec + PH + 2 * PH * (clampr(int'(decim_ratio)) - 1) + 1;
         end else begin
            k = ec - e0;
            ex_pdm = ((k / PH) % 2) == 1;
            ex_se  = (k % (2 * PH)) == PH;
            if (ec == next_decim) begin
               ex_de = 1;
               pend_d.push_back(ec);
               next_decim = ec + 2 * PH * clampr(int'(decim_ratio));
            end
         end
         if (pend_d.size() != 0 && ec == pend_d[0] + 1 + CL) begin
            void'(pend_d.pop_front());
            if (q.size() == 0) begin
               for (int c = 0; c < NCH; c++) q.push_back('{d: cic_data[c*W +: W], ch: 2'(c)});
            end else begin
               ovr_set = 1;
            end
         end
         if (ovr_set) ovr = 1;
         else if (clear_overrun) ovr = 0;
      end
   endtask

   task automatic compare();
      bit busy_exp;
      busy_exp = (q.size() != 0) || (pend_d.size() != 0 && ec > pend_d[0]);
      check("pdm_clk", pdm_clk, ex_pdm);
      check("pdm_sample_en", pdm_sample_en, ex_se);
      check("decim_en", decim_en, ex_de);
      check("m_valid", m_valid, q.size() != 0);
      check("busy", busy, busy_exp);
      check("overrun", overrun, ovr);
      if (q.size() != 0) begin
         check("m_data", m_data, q[0].d);
         check("m_chan", m_chan, q[0].ch);
         check("m_first", m_first, q[0].ch == 0);
         check("m_last", m_last, q[0].ch == NCH - 1);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic wait_decim(output int edge_no);
      bit found = 0;
      edge_no = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick();
         if (decim_en === 1'b1) begin
            found = 1; edge_no = ec;
         end
      end
      check("decim_seen", found, 1);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_m_valid"}, m_valid, 0);
      check({tag, "_m_data"}, m_data, 0);
      check({tag, "_m_chan"}, m_chan, 0);
      check({tag, "_m_first"}, m_first, 0);
      check({tag, "_m_last"}, m_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_overrun"}, overrun, 0);
      check({tag, "_pdm_clk"}, pdm_clk, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d[0:6];
      int found;
      int de_seen;

      // Reset state
      rst = 1; enable = 0; decim_ratio = 8'd4; m_ready = 1; clear_overrun = 0;
      cic_data = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
      repeat (3) tick();
      check_zero_outputs("reset");

      // Enable with ratio 4, fixed channel data, free-running sink
      rst = 0; enable = 1;
      repeat (60) tick();

      // Stall the sink right after a capture: word 0 held, next frame dropped
      found = 0;
      for (int i = 0; i < 80 && found == 0; i++) begin
         tick();
         if (q.size() == NCH) found = 1;
      end
      check("s3_frame_loaded", found, 1);
      cic_data = {16'hdddd, 16'hcccc, 16'hbbbb, 16'haaaa};
      m_ready = 0;
      repeat (40) tick();
      check("s3_overrun", overrun, 1);
      check("s3_word0_held", m_data, 16'h0001);
      m_ready = 1;
      repeat (20) tick();

      // Ratio changes only take effect on frame boundaries
      cic_data = {$urandom, $urandom};
      wait_decim(d[0]);
      repeat (5) tick();
      decim_ratio = 8'd8;
      wait_decim(d[1]);
      wait_decim(d[2]);
      decim_ratio = 8'd0;
      wait_decim(d[3]);
      wait_decim(d[4]);
      decim_ratio = 8'd1;
      wait_decim(d[5]);
      wait_decim(d[6]);
      check("s4_int_4_mid", d[1] - d[0], 16);
      check("s4_int_8", d[2] - d[1], 32);
      check("s4_int_8_again", d[3] - d[2], 32);
      check("s4_int_r0", d[4] - d[3], 8);
      check("s4_int_r0_b", d[5] - d[4], 8);
      check("s4_int_r1", d[6] - d[5], 8);

      // clear_overrun coinciding with a new drop: set wins
      decim_ratio = 8'd2;
      m_ready = 0;
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         tick();
         if (q.size() != 0 && pend_d.size() != 0 && pend_d[0] + 1 + CL == ec + 1 && ovr) found = 1;
      end
      check("s5_drop_edge_found", found, 1);
      clear_overrun = 1;
      tick();
      clear_overrun = 0;
      check("s5_set_wins", overrun, 1);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         if (!(pend_d.size() != 0 && pend_d[0] + 1 + CL == ec + 1)) found = 1;
         else tick();
      end
      clear_overrun = 1;
      tick();
      clear_overrun = 0;
      check("s5_cleared", overrun, 0);
      m_ready = 1;
      repeat (40) tick();

      // Randomised traffic
      for (int i = 0; i < 900; i++) begin
         cic_data = {$urandom, $urandom};
         m_ready = ($urandom % 4) != 0;
         if ($urandom % 60 == 0) decim_ratio = 8'($urandom % 7);
         clear_overrun = ($urandom % 30) == 0;
         if ($urandom % 200 == 0) enable = ~enable;
         tick();
      end
      enable = 1; clear_overrun = 0; decim_ratio = 8'd3;

      // enable dropped mid-drain: drain completes, strobes stop
      m_ready = 0;
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         tick();
         if (q.size() != 0) found = 1;
      end
      check("s7_frame_seen", found, 1);
      enable = 0;
      m_ready = 1;
      de_seen = 0;
      repeat (60) begin
         tick();
         if (decim_en === 1'b1) de_seen++;
      end
      check("s7_no_decim", de_seen, 0);
      check("s7_drained", m_valid, 0);
      check("s7_pdm_low", pdm_clk, 0);

      // Reset mid-drain
      enable = 1;
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         tick();
         if (q.size() != 0 && q[0].ch == 2) found = 1;
      end
      check("s8_mid_drain", found, 1);
      rst = 1;
      tick();
      check_zero_outputs("s8_rst");
      rst = 0; enable = 0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
